// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - control stage for unsigned restoring division driving an external quotient step
module divider_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] step_r_in,
    output logic [WIDTH-1:0] step_d,
    output logic [WIDTH-1:0] step_q_in,
    input  logic [WIDTH-1:0] step_r_out,
    input  logic [WIDTH-1:0] step_q_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int          CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count;
    logic             dbz_q;

    assign step_r_in = {r_q[WIDTH-2:0], dvd_sh[WIDTH-1]};
    assign step_d    = d_q;
    assign step_q_in = q_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            r_q    <= '0;
            q_q    <= '0;
            dvd_sh <= '0;
            d_q    <= '0;
            count  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd_sh <= dividend;
                        d_q    <= divisor;
                        count  <= '0;
                        // A zero divisor skips the iterations and presents the fixed result directly
                        if (divisor == '0) begin
                            r_q   <= dividend;
                            q_q   <= '1;
                            dbz_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            r_q   <= '0;
                            q_q   <= '0;
                            dbz_q <= 1'b0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    dvd_sh <= dvd_sh << 1;
                    count  <= count + 1'b1;
                    // With R's top bit set the shifted value exceeds 2^WIDTH, so the step's
                    // compare is meaningless; the subtraction always succeeds.
                    if (!r_q[WIDTH-1]) begin
                        r_q <= step_r_out;
                        q_q <= step_q_out;
                    end else begin
                        r_q <= step_r_in - d_q;
                        q_q <= {q_q[WIDTH-2:0], 1'b1};
                    end
                    if (count == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                        dbz_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign quotient    = out_valid ? q_q : '0;
    assign remainder   = out_valid ? r_q : '0;
    assign div_by_zero = out_valid & dbz_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - self-checking bench for divider_sequencer with a combinational restoring step
module tb_divider_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] step_r_in;
    logic [31:0] step_d;
    logic [31:0] step_q_in;
    logic [31:0] step_r_out;
    logic [31:0] step_q_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    divider_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .step_r_in(step_r_in), .step_d(step_d), .step_q_in(step_q_in),
        .step_r_out(step_r_out), .step_q_out(step_q_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // External one-bit restoring step: subtract when the shifted remainder covers the divisor
    always_comb begin
        step_r_out = step_r_in;
        step_q_out = {step_q_in[30:0], 1'b0};
        if (step_r_in >= step_d) begin
            step_r_out = step_r_in - step_d;
            step_q_out = {step_q_in[30:0], 1'b1};
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents operands, waits for the result (edges counted including the accept edge), then completes the handshake
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output int lat);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output int lat);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
            lat = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
            lat = 33;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 255));
            5: return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] gq, gr, eq, er;
        logic        gz, ez;
        int          glat, elat;

        tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        tbl[1] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 33};
        tbl[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
        tbl[3] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1};
        tbl[4] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 33};
        tbl[5] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
        tbl[6] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1};
        tbl[7] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 33};
        tbl[8] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 33};
        tbl[9] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0, 33};

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset div_by_zero", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].a, tbl[i].b, gq, gr, gz, glat);
            chk($sformatf("tbl%0d quotient", i), gq, tbl[i].q);
            chk($sformatf("tbl%0d remainder", i), gr, tbl[i].r);
            chk($sformatf("tbl%0d div_by_zero", i), 32'(gz), 32'(tbl[i].z));
            chk($sformatf("tbl%0d latency", i), 32'(glat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d idle quotient", i), quotient, 32'd0);
            chk($sformatf("tbl%0d idle in_ready", i), 32'(in_ready), 32'd1);
        end

        // Held result under back-pressure, with stray start pulses during RUN and DONE
        begin
            int lat = 1;
            start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
            tick();
            start = 1'b0;
            repeat (5) begin tick(); lat++; end
            start = 1'b1; dividend = 32'd77; divisor = 32'd0;
            tick(); lat++;
            start = 1'b0;
            while (!out_valid && lat < 100) begin tick(); lat++; end
            chk("hold latency", 32'(lat), 32'd33);
            for (int c = 0; c < 10; c++) begin
                start = (c == 3);
                dividend = 32'd9; divisor = 32'd2;
                chk($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
                chk($sformatf("hold%0d quotient", c), quotient, 32'd333);
                chk($sformatf("hold%0d remainder", c), remainder, 32'd1);
                tick();
            end
            start = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("hold released in_ready", 32'(in_ready), 32'd1);
        end

        // Reset at RUN iteration 16 aborts the division
        start = 1'b1; dividend = 32'd12345; divisor = 32'd7;
        tick();
        start = 1'b0;
        repeat (16) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        repeat (40) begin
            if (out_valid) chk("abort spurious out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        do_op(32'd50, 32'd5, gq, gr, gz, glat);
        chk("after abort quotient", gq, 32'd10);
        chk("after abort remainder", gr, 32'd0);
        chk("after abort latency", 32'(glat), 32'd33);

        for (int k = 0; k < 2000; k++) begin
            logic [31:0] a, b;
            a = pick_operand();
            b = pick_operand();
            model(a, b, eq, er, ez, elat);
            do_op(a, b, gq, gr, gz, glat);
            chk($sformatf("rnd%0d %h/%h quotient", k, a, b), gq, eq);
            chk($sformatf("rnd%0d %h/%h remainder", k, a, b), gr, er);
            chk($sformatf("rnd%0d div_by_zero", k), 32'(gz), 32'(ez));
            chk($sformatf("rnd%0d latency", k), 32'(glat), 32'(elat));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
